// File: rtl/perf_traffic_gen.sv
// Synthetic AXI-stream packet source: per-class token buckets feed a round-robin
// arbiter; each granted packet is streamed with class/length sideband.
module perf_traffic_gen #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int CLASS_COUNT     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [CLASS_COUNT-1:0]       cfg_class_en,
  input  logic [16*CLASS_COUNT-1:0]    cfg_pk_len,
  input  logic [16*CLASS_COUNT-1:0]    cfg_rate,
  input  logic [16*CLASS_COUNT-1:0]    cfg_burst,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [4:0]                   m_flow_class,
  output logic [15:0]                  m_pk_len,
  output logic [31:0]                  sent_pk_count,
  output logic [47:0]                  sent_byte_count,
  output logic [0:0]                   o_dbg_state
);

  localparam int KW = AXIS_KEEP_WIDTH;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // Handshake: a beat transfers on a rising edge where m_axis_tvalid and
  // m_axis_tready are both high; once raised, tvalid and all beat/sideband
  // outputs hold until that transfer happens.

  logic [0:0]                 r_state;
  logic [2:0]                 r_rr_ptr;
  logic [31:0]                r_credit [CLASS_COUNT];
  logic [31:0]                r_seq    [CLASS_COUNT];
  logic [15:0]                r_beats;
  logic [15:0]                r_beat_idx;
  logic [AXIS_DATA_WIDTH-1:0] r_tdata;
  logic [KW-1:0]              r_tkeep;
  logic                       r_tvalid;
  logic                       r_tlast;
  logic [4:0]                 r_class;
  logic [15:0]                r_len;
  logic [31:0]                r_pk_count;
  logic [47:0]                r_byte_count;

  logic [15:0]                w_len    [CLASS_COUNT];
  logic [31:0]                w_cost   [CLASS_COUNT];
  logic [31:0]                w_cap    [CLASS_COUNT];
  logic [33:0]                w_sum    [CLASS_COUNT];
  logic [31:0]                w_credit_next [CLASS_COUNT];
  logic [CLASS_COUNT-1:0]     w_elig;
  logic                       w_grant_any;
  logic [2:0]                 w_grant_idx;
  logic                       w_grant;
  int                         w_idx;
  logic [15:0]                w_g_len;
  logic [16:0]                w_g_sum;
  logic [15:0]                w_g_beats;
  logic [AXIS_DATA_WIDTH-1:0] w_beat0;
  logic                       w_accept;
  logic                       w_last_beat;
  logic [15:0]                w_next_idx;

  function automatic logic [KW-1:0] f_keep(input logic [15:0] len, input logic last);
    logic [15:0] rem;
    rem = len % 16'(KW);
    f_keep = '1;
    if (last && rem != 16'd0) f_keep = ~({KW{1'b1}} << rem);
  endfunction

  always_comb begin
    w_elig = '0;
    for (int c = 0; c < CLASS_COUNT; c++) begin
      w_len[c]  = (cfg_pk_len[16*c +: 16] < 16'd64) ? 16'd64 : cfg_pk_len[16*c +: 16];
      w_cost[c] = {8'd0, w_len[c], 8'd0};
      w_cap[c]  = (cfg_burst[16*c +: 16] > w_len[c]) ? {8'd0, cfg_burst[16*c +: 16], 8'd0}
                                                     : w_cost[c];
      w_elig[c] = enable && cfg_class_en[c] && (r_credit[c] >= w_cost[c]);
    end
  end

  // Search upward from the class after the last grant, wrapping.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    for (int i = 1; i <= CLASS_COUNT; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % CLASS_COUNT;
      if (!w_grant_any && w_elig[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = 3'(w_idx);
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_grant_any;

  always_comb begin
    for (int c = 0; c < CLASS_COUNT; c++) begin
      w_sum[c] = {2'b00, r_credit[c]} + 34'(cfg_rate[16*c +: 16])
               - ((w_grant && w_grant_idx == 3'(c)) ? {2'b00, w_cost[c]} : 34'd0);
      w_credit_next[c] = (w_sum[c] > {2'b00, w_cap[c]}) ? w_cap[c] : w_sum[c][31:0];
    end
  end

  always_comb begin
    w_g_len   = w_len[w_grant_idx];
    w_g_sum   = {1'b0, w_g_len} + 17'(KW - 1);
    w_g_beats = 16'(w_g_sum / 17'(KW));
    w_beat0          = '0;
    w_beat0[15:0]    = w_g_len;
    w_beat0[20:16]   = 5'(w_grant_idx);
    w_beat0[63:32]   = r_seq[w_grant_idx];
  end

  assign w_accept    = r_tvalid && m_axis_tready;
  assign w_last_beat = (r_beat_idx == r_beats - 16'd1);
  assign w_next_idx  = r_beat_idx + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CLASS_COUNT; c++) r_credit[c] <= '0;
    end else begin
      for (int c = 0; c < CLASS_COUNT; c++)
        r_credit[c] <= cfg_class_en[c] ? w_credit_next[c] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 3'(CLASS_COUNT - 1);
      for (int c = 0; c < CLASS_COUNT; c++) r_seq[c] <= '0;
      r_beats      <= '0;
      r_beat_idx   <= '0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_class      <= '0;
      r_len        <= '0;
      r_pk_count   <= '0;
      r_byte_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state            <= S_SEND;
            r_rr_ptr           <= w_grant_idx;
            r_seq[w_grant_idx] <= r_seq[w_grant_idx] + 32'd1;
            r_class            <= 5'(w_grant_idx);
            r_len              <= w_g_len;
            r_beats            <= w_g_beats;
            r_beat_idx         <= '0;
            r_tdata            <= w_beat0;
            r_tkeep            <= f_keep(w_g_len, w_g_beats == 16'd1);
            r_tlast            <= (w_g_beats == 16'd1);
            r_tvalid           <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_state      <= S_IDLE;
              r_tvalid     <= 1'b0;
              r_tlast      <= 1'b0;
              r_tdata      <= '0;
              r_tkeep      <= '0;
              r_pk_count   <= r_pk_count + 32'd1;
              r_byte_count <= r_byte_count + {32'd0, r_len};
            end else begin
              r_beat_idx <= w_next_idx;
              r_tdata    <= {KW{w_next_idx[7:0]}};
              r_tkeep    <= f_keep(r_len, w_next_idx == r_beats - 16'd1);
              r_tlast    <= (w_next_idx == r_beats - 16'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axis_tdata    = r_tdata;
  assign m_axis_tkeep    = r_tkeep;
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tlast    = r_tlast;
  assign m_flow_class    = r_class;
  assign m_pk_len        = r_len;
  assign sent_pk_count   = r_pk_count;
  assign sent_byte_count = r_byte_count;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_perf_traffic_gen.sv
// Bench for perf_traffic_gen: directed rate/fairness/reset scenarios plus random
// config and backpressure, checked by a packet-level monitor model.
module tb_perf_traffic_gen;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int NC = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic tready = 1'b1;
  bit   bp_mode = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;

  logic [NC-1:0] cfg_en = '0;
  logic [15:0]   cfg_len [NC];
  logic [15:0]   cfg_rt  [NC];
  logic [15:0]   cfg_bu  [NC];
  logic [16*NC-1:0] w_len_bus, w_rate_bus, w_burst_bus;

  always_comb begin
    w_len_bus = '0; w_rate_bus = '0; w_burst_bus = '0;
    for (int c = 0; c < NC; c++) begin
      w_len_bus[16*c +: 16]   = cfg_len[c];
      w_rate_bus[16*c +: 16]  = cfg_rt[c];
      w_burst_bus[16*c +: 16] = cfg_bu[c];
    end
  end

  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast;
  logic [4:0]    m_flow_class;
  logic [15:0]   m_pk_len;
  logic [31:0]   sent_pk_count;
  logic [47:0]   sent_byte_count;
  logic [0:0]    dbg_state;

  perf_traffic_gen #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .CLASS_COUNT(NC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_class_en(cfg_en),
    .cfg_pk_len(w_len_bus), .cfg_rate(w_rate_bus), .cfg_burst(w_burst_bus),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(tready), .m_axis_tlast(m_axis_tlast), .m_flow_class(m_flow_class),
    .m_pk_len(m_pk_len), .sent_pk_count(sent_pk_count), .sent_byte_count(sent_byte_count),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] eff_len(input logic [15:0] l);
    return (l < 16'd64) ? 16'd64 : l;
  endfunction

  // scoreboard / monitor state
  logic [4:0]  exp_q [$];
  int          start_q [$];
  logic [4:0]  cls_q [$];
  logic [31:0] seq_q [$];
  int          mon_beat = 0, mon_beats = 1, mon_pkts = 0;
  longint      mon_bytes = 0;
  logic [15:0] mon_L = 16'd64;
  logic [4:0]  mon_cls = '0;
  logic [31:0] exp_seq [NC];
  bit          prev_stall = 1'b0;
  logic [DW-1:0] p_data;
  logic [KW-1:0] p_keep;
  logic          p_last;
  logic [4:0]    p_cls;
  logic [15:0]   p_len;

  // Samples 1 ns after the falling edge: inputs are already driven for the next rising edge.
  always @(negedge clk) begin
    logic [DW-1:0] e_data;
    logic [KW-1:0] e_keep;
    logic          ok;
    int            r;
    #1;
    if (rst) begin
      mon_beat = 0; prev_stall = 1'b0; mon_pkts = 0; mon_bytes = 0;
      for (int c = 0; c < NC; c++) exp_seq[c] = '0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_data", m_axis_tdata, p_data);
        check("hold_keep", m_axis_tkeep, p_keep);
        check("hold_last", m_axis_tlast, p_last);
        check("hold_class", m_flow_class, p_cls);
        check("hold_len", m_pk_len, p_len);
      end
      if (m_axis_tvalid) begin
        if (mon_beat == 0) begin
          mon_cls = m_flow_class;
          ok = (mon_cls < NC) ? cfg_en[mon_cls[2:0]] : 1'b0;
          check("class_enabled", ok, 1'b1);
          mon_L = eff_len(cfg_len[ok ? mon_cls[2:0] : 3'd0]);
          mon_beats = (int'(mon_L) + KW - 1) / KW;
          e_data = '0;
          e_data[15:0]  = mon_L;
          e_data[20:16] = mon_cls;
          e_data[63:32] = exp_seq[ok ? mon_cls[2:0] : 3'd0];
        end else begin
          check("class_stable", m_flow_class, mon_cls);
          for (int b = 0; b < KW; b++) e_data[8*b +: 8] = 8'(mon_beat);
        end
        r = int'(mon_L) % KW;
        e_keep = '1;
        if (mon_beat == mon_beats - 1 && r != 0) begin
          e_keep = '0;
          for (int b = 0; b < r; b++) e_keep[b] = 1'b1;
        end
        check("pk_len", m_pk_len, mon_L);
        check("tdata", m_axis_tdata, e_data);
        check("tkeep", m_axis_tkeep, e_keep);
        check("tlast", m_axis_tlast, mon_beat == mon_beats - 1);
        if (tready) begin
          if (mon_beat == 0) begin
            start_q.push_back(cyc);
            cls_q.push_back(mon_cls);
            seq_q.push_back(m_axis_tdata[63:32]);
          end
          if (mon_beat == mon_beats - 1) begin
            mon_pkts++;
            mon_bytes += longint'(mon_L);
            exp_seq[mon_cls[2:0]] = exp_seq[mon_cls[2:0]] + 32'd1;
            mon_beat = 0;
          end else begin
            mon_beat++;
          end
        end
      end
      prev_stall = m_axis_tvalid && !tready;
      p_data = m_axis_tdata; p_keep = m_axis_tkeep; p_last = m_axis_tlast;
      p_cls = m_flow_class; p_len = m_pk_len;
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    start_q.delete(); cls_q.delete(); seq_q.delete();
  endtask

  task automatic cfg_single(input logic [15:0] len, input logic [15:0] rate, input logic [15:0] burst);
    cfg_en = 5'b00001;
    for (int c = 0; c < NC; c++) begin
      cfg_len[c] = 16'($urandom_range(1, 500));
      cfg_rt[c]  = 16'h4000;
      cfg_bu[c]  = 16'd0;
    end
    cfg_len[0] = len; cfg_rt[0] = rate; cfg_bu[0] = burst;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int t = 0;
    while (mon_pkts < n && t < budget) begin step(); t++; end
    check("timeout_pkts", mon_pkts >= n, 1'b1);
  endtask

  task automatic wait_beat1(input int budget);
    int t = 0;
    while (!(mon_beat == 1 && m_axis_tvalid) && t < budget) begin step(); t++; end
    check("timeout_beat1", mon_beat == 1 && m_axis_tvalid, 1'b1);
  endtask

  task automatic check_spacing(input string tag, input int n, input int gap);
    for (int i = 1; i < n && i < start_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), start_q[i] - start_q[i-1], gap);
  endtask

  initial begin
    int rel, base, vcnt;
    bit seen;
    cfg_single(16'd128, 16'h4000, 16'd128);
    for (int c = 0; c < NC; c++) exp_seq[c] = '0;

    // reset state
    step(); step(); step();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tkeep", m_axis_tkeep, '0);
    check("rst_class", m_flow_class, '0);
    check("rst_len", m_pk_len, '0);
    check("rst_pkcnt", sent_pk_count, '0);
    check("rst_bytecnt", sent_byte_count, '0);
    check("rst_state", dbg_state, 1'b0);

    // full-length packets
    do_reset();
    enable = 1'b1;
    wait_pkts(10, 300);
    enable = 1'b0;
    repeat (10) step();
    check_spacing("full_gap", 10, 3);
    for (int i = 0; i < 10 && i < seq_q.size(); i++) check($sformatf("full_seq_%0d", i), seq_q[i], 32'(i));
    check("full_pkcnt", sent_pk_count, 32'(mon_pkts));
    check("full_bytecnt", sent_byte_count, 48'(128 * mon_pkts));

    // partial last beat, then short packet padded to 64
    cfg_single(16'd100, 16'h4000, 16'd100);
    do_reset();
    enable = 1'b1;
    wait_pkts(4, 200);
    enable = 1'b0;
    repeat (10) step();
    check("part_bytecnt", sent_byte_count, 48'(100 * mon_pkts));
    cfg_single(16'd40, 16'h4000, 16'd0);
    do_reset();
    enable = 1'b1;
    wait_pkts(4, 200);
    enable = 1'b0;
    repeat (10) step();
    check_spacing("short_gap", 4, 2);
    check("short_bytecnt", sent_byte_count, 48'(64 * mon_pkts));

    // rate limiting: 1 B/cycle, 256-byte packets
    cfg_single(16'd256, 16'h0100, 16'd256);
    enable = 1'b1;
    do_reset();
    rel = cyc;
    wait_pkts(4, 1400);
    enable = 1'b0;
    repeat (10) step();
    if (start_q.size() > 0) begin
      check("rate_first_lo", (start_q[0] - rel) >= 250, 1'b1);
      check("rate_first_hi", (start_q[0] - rel) <= 262, 1'b1);
    end
    check_spacing("rate_gap", 4, 256);

    // round-robin fairness between classes 0 and 2
    cfg_single(16'd64, 16'h4000, 16'd64);
    cfg_en = 5'b00101;
    cfg_len[2] = 16'd64; cfg_rt[2] = 16'h4000; cfg_bu[2] = 16'd64;
    do_reset();
    enable = 1'b1;
    wait_pkts(10, 200);
    enable = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 2 == 0) ? 5'd0 : 5'd2);
    for (int i = 0; i < 10 && i < cls_q.size(); i++) check($sformatf("rr_class_%0d", i), cls_q[i], exp_q.pop_front());
    exp_q.delete();
    check_spacing("rr_gap", 10, 2);

    // random config with random backpressure
    for (int round = 0; round < 3; round++) begin
      cfg_en = 5'($urandom_range(1, 31));
      for (int c = 0; c < NC; c++) begin
        cfg_len[c] = 16'($urandom_range(1, 300));
        cfg_rt[c]  = 16'($urandom_range(16'h0400, 16'h8000));
        cfg_bu[c]  = 16'($urandom_range(0, 600));
      end
      bp_mode = 1'b1;
      enable = 1'b1;
      do_reset();
      repeat (800) step();
      enable = 1'b0;
      bp_mode = 1'b0;
      repeat (40) step();
      check($sformatf("bp_idle_%0d", round), m_axis_tvalid, 1'b0);
      check($sformatf("bp_some_%0d", round), mon_pkts > 0, 1'b1);
      check($sformatf("bp_pkcnt_%0d", round), sent_pk_count, 32'(mon_pkts));
      check($sformatf("bp_bytecnt_%0d", round), sent_byte_count, 48'(mon_bytes));
      for (int c = 0; c < NC; c++) begin
        if (cfg_en[c]) begin
          seen = 1'b0;
          foreach (cls_q[i]) if (cls_q[i] == 5'(c)) seen = 1'b1;
          check($sformatf("bp_seen_%0d_%0d", round, c), seen, 1'b1);
        end
      end
    end

    // reset asserted on beat 1 of a 3-beat packet
    cfg_single(16'd192, 16'h4000, 16'd192);
    do_reset();
    enable = 1'b1;
    wait_pkts(3, 200);
    wait_beat1(50);
    rst = 1'b1;
    step();
    check("mrst_tvalid", m_axis_tvalid, 1'b0);
    check("mrst_tlast", m_axis_tlast, 1'b0);
    check("mrst_pkcnt", sent_pk_count, '0);
    check("mrst_bytecnt", sent_byte_count, '0);
    rst = 1'b0;
    seq_q.delete(); start_q.delete(); cls_q.delete();
    wait_pkts(1, 200);
    if (seq_q.size() > 0) check("mrst_seq0", seq_q[0], 32'd0);
    check("mrst_count_seen", seq_q.size() > 0, 1'b1);

    // enable dropped mid-packet
    do_reset();
    enable = 1'b1;
    wait_beat1(200);
    enable = 1'b0;
    base = mon_pkts;
    repeat (10) step();
    check("en_completed", mon_pkts, base + 1);
    vcnt = 0;
    repeat (30) begin step(); if (m_axis_tvalid) vcnt++; end
    check("en_no_more", vcnt, 0);
    check("en_pkcnt", sent_pk_count, 32'(mon_pkts));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/perf_traffic_gen.md
# perf_traffic_gen

Synthetic AXI-stream packet source that drives the RX datapath under test, the transmit end of the stream that the performance counter measures. It generates packets for up to five flow classes. Each class has its own token-bucket rate limiter, and a round-robin arbiter picks among the eligible classes. Every packet is presented with its flow class and length as sideband, in the same form the counter consumes (`s_flow_class`, `s_pk_len`). Used in simulation and on-board throughput/fairness tests.

## Interface
- `AXIS_DATA_WIDTH`, 512: stream data width in bits.
- `AXIS_KEEP_WIDTH`, `AXIS_DATA_WIDTH/8`: bytes per beat (B).
- `CLASS_COUNT`, 5: number of flow classes, 1..5.
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: allow new packet starts.
- `cfg_class_en`  in  CLASS_COUNT: per-class enable.
- `cfg_pk_len`  in  16*CLASS_COUNT: per-class packet length in bytes; values <64 are treated as 64.
- `cfg_rate`  in  16*CLASS_COUNT: per-class credit added each cycle, bytes/cycle in Q8.8.
- `cfg_burst`  in  16*CLASS_COUNT: per-class credit cap in bytes.
- `m_axis_tdata`  out  AXIS_DATA_WIDTH: beat data.
- `m_axis_tkeep`  out  AXIS_KEEP_WIDTH: byte enables.
- `m_axis_tvalid`  out  1: beat valid.
- `m_axis_tready`  in  1: sink ready.
- `m_axis_tlast`  out  1: last beat of packet.
- `m_flow_class`  out  5: class of the current packet, held for the whole packet.
- `m_pk_len`  out  16: effective length of the current packet, held for the whole packet.
- `sent_pk_count`  out  32: packets completed, wraps.
- `sent_byte_count`  out  48: bytes completed, wraps.

## Operation
- **Credit.** One 32-bit Q24.8 register per class.
  - Each cycle: `credit_next = min(cap, credit + rate − (grant ? L<<8 : 0))`.
  - `cap = max(cfg_burst, L) << 8`, where L is the effective length; this guarantees every enabled class can eventually send.
  - Eligibility is evaluated on the current (pre-update) credit.
  - A class with `cfg_class_en=0` has its credit forced to 0.
- **Eligible** when `enable && cfg_class_en[c] && credit[c] >= L[c]<<8`.
- **Arbiter.** Round-robin over the eligible classes, searching upward from `rr_ptr+1` modulo CLASS_COUNT. `rr_ptr` is set to the granted class. It resets to CLASS_COUNT−1, so class 0 has first priority.
- **FSM.**
  - **IDLE:** if any class is eligible, grant it; latch class, L, `beats = ceil(L/B)`, `beat_idx = 0`; subtract credit; go to SEND.
  - **SEND:** `m_axis_tvalid = 1`.
    - On each accepted beat, `beat_idx` increments.
    - On an accepted beat with `beat_idx == beats−1`: `tlast = 1`, `sent_pk_count += 1`, `sent_byte_count += L`, return to IDLE.
- **Beat contents.**
  - Beat 0: `[15:0] = L`, `[20:16] = class`, `[63:32]` = per-class sequence number (32-bit, wraps, incremented at grant). All other bits carry the replicated pattern `{beat_idx[7:0]}`.
  - Beats 1..n: every byte = `beat_idx[7:0]`.
- **tkeep.** All ones except on the last beat, where it is the low `r = L mod B` bits set (all ones if r = 0).
- **`enable` falling mid-packet.** The current packet completes; no new grant is made.
- **Config changes mid-packet.** They take effect at the next grant only; latched values are stable for the whole packet.

## Timing
- **Reset values.** After the `rst` edge: `tvalid`/`tlast` = 0, `tdata`/`tkeep` = 0, `m_flow_class`/`m_pk_len` = 0, counters = 0, credits = 0, sequence numbers = 0, FSM = IDLE. This applies equally when reset is asserted mid-packet: the packet is truncated and no tlast is emitted.
- **Grant latency.** A grant in IDLE at edge k gives `tvalid = 1` from cycle k+1.
- **Packet spacing.** There is one IDLE bubble between packets, so the minimum packet period is `beats+1` cycles.
- **AXI-stream rules.** While `tvalid=1 && tready=0`, `tdata`, `tkeep`, `tlast`, `m_flow_class` and `m_pk_len` are held stable. `tvalid` never drops before the beat is accepted.
- **Credit under backpressure.** Credit keeps accruing during SEND and under backpressure, up to cap.

## Test plan
- **Full-length packets.** Class 0 only, rate 0x4000, L=128, burst 128, tready=1.
  - Expect 2-beat packets with tkeep all ones.
  - Beat 0 `[15:0]=128`, `[20:16]=0`, seq 0,1,2…
  - One bubble between packets; `sent_byte_count` = 128×`sent_pk_count`.
- **Partial last beat.** L=100.
  - Expect 2 beats; last tkeep = `0x0000000FFFFFFFFF` (36 bytes).
  - L=40 is sent as 64 bytes: 1 beat, `m_pk_len=64`.
- **Rate limiting.** Rate 0x0100 (1 B/cycle), L=256, burst 256.
  - First grant about 256 cycles after enable; subsequent packet starts 256 cycles apart.
- **Round-robin fairness.** Classes 0 and 2 enabled, both saturated (rate 0x4000, L=64).
  - Classes alternate 0,2,0,2; class 1 never appears.
- **Backpressure.** tready toggled randomly.
  - Outputs stay stable while stalled; beat order is intact; counts match the packets sent.
- **Reset and enable.**
  - `rst` asserted on beat 1 of 3: next cycle `tvalid=0`, counters=0; restart begins with seq 0.
  - `enable` deasserted mid-packet: the packet completes, then `tvalid` stays 0.
